// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Watches a multiplexed, active-low 7-segment display bus and
//               reconstructs the 4-digit hex value being shown. Each digit
//               must be stable for STABLE_CYCLES samples before it is
//               decoded; a frame is published once all four digits have been
//               captured.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        CLK100MHZ,
    input  logic        BTNR,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        valid,
    output logic        frame_done,
    output logic        bad_pattern
);

    localparam logic [1:0] c_st_wait   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_held   = 2'd2;
    localparam logic [7:0] c_stable    = 8'(STABLE_CYCLES);

    logic [6:0]  r_seg;
    logic [3:0]  r_an;
    logic [6:0]  r_prev_seg;
    logic [3:0]  r_prev_an;
    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_shadow;
    logic [3:0]  r_mask;
    logic [15:0] r_value;
    logic        r_valid;
    logic        r_frame_done;
    logic        r_bad_pattern;

    logic        w_legal;
    logic        w_same;
    logic [1:0]  w_idx;
    logic        w_ok;
    logic [3:0]  w_nib;
    logic [1:0]  w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_capture;
    logic        w_publish;
    logic [3:0]  w_mask_base;

    // Register the raw bus once, and keep the previous sample for the
    // stability comparison.
    always_ff @(posedge CLK100MHZ) begin
        if (BTNR) begin
            r_seg      <= 7'h7F;
            r_an       <= 4'hF;
            r_prev_seg <= 7'h7F;
            r_prev_an  <= 4'hF;
        end else begin
            r_seg      <= seg;
            r_an       <= an;
            r_prev_seg <= r_seg;
            r_prev_an  <= r_an;
        end
    end

    // Exactly one anode low selects a digit; anything else is idle.
    always_comb begin
        w_legal = 1'b1;
        w_idx   = 2'd0;
        case (r_an)
            4'hE:    w_idx = 2'd0;
            4'hD:    w_idx = 2'd1;
            4'hB:    w_idx = 2'd2;
            4'h7:    w_idx = 2'd3;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_same = ({r_an, r_seg} == {r_prev_an, r_prev_seg});

    // Segment pattern (active-low, g..a) to hex nibble.
    always_comb begin
        w_ok  = 1'b1;
        w_nib = 4'h0;
        case (r_seg)
            7'h40:   w_nib = 4'h0;
            7'h79:   w_nib = 4'h1;
            7'h24:   w_nib = 4'h2;
            7'h30:   w_nib = 4'h3;
            7'h19:   w_nib = 4'h4;
            7'h12:   w_nib = 4'h5;
            7'h02:   w_nib = 4'h6;
            7'h78:   w_nib = 4'h7;
            7'h00:   w_nib = 4'h8;
            7'h10:   w_nib = 4'h9;
            7'h08:   w_nib = 4'hA;
            7'h03:   w_nib = 4'hB;
            7'h46:   w_nib = 4'hC;
            7'h21:   w_nib = 4'hD;
            7'h06:   w_nib = 4'hE;
            7'h0E:   w_nib = 4'hF;
            default: w_ok  = 1'b0;
        endcase
    end

    // Stability FSM: a digit is decoded exactly once, on the cycle its
    // run of identical samples reaches STABLE_CYCLES.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            c_st_wait: begin
                if (w_legal) begin
                    w_state_nxt = c_st_settle;
                    w_cnt_nxt   = 8'd1;
                end
            end
            c_st_settle: begin
                if (w_same) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (w_cnt_nxt == c_stable) begin
                        w_capture   = 1'b1;
                        w_state_nxt = c_st_held;
                    end
                end else if (w_legal) begin
                    w_cnt_nxt = 8'd1;
                end else begin
                    w_state_nxt = c_st_wait;
                    w_cnt_nxt   = 8'd0;
                end
            end
            c_st_held: begin
                if (!w_same) begin
                    if (w_legal) begin
                        w_state_nxt = c_st_settle;
                        w_cnt_nxt   = 8'd1;
                    end else begin
                        w_state_nxt = c_st_wait;
                        w_cnt_nxt   = 8'd0;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_wait;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // A full mask publishes on the following cycle; a decode landing in
    // that same cycle starts the next frame's mask.
    assign w_publish   = (r_mask == 4'hF);
    assign w_mask_base = w_publish ? 4'h0 : r_mask;

    // State, capture shadow, mask and published outputs.
    always_ff @(posedge CLK100MHZ) begin
        if (BTNR) begin
            r_state       <= c_st_wait;
            r_cnt         <= 8'd0;
            r_shadow      <= 16'h0000;
            r_mask        <= 4'h0;
            r_value       <= 16'h0000;
            r_valid       <= 1'b0;
            r_frame_done  <= 1'b0;
            r_bad_pattern <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_frame_done  <= w_publish;
            r_bad_pattern <= 1'b0;
            if (w_publish) begin
                r_value <= r_shadow;
                r_valid <= 1'b1;
            end
            if (w_capture && w_ok) begin
                r_shadow[{w_idx, 2'b00} +: 4] <= w_nib;
                r_mask <= w_mask_base | (4'b0001 << w_idx);
            end else if (w_capture) begin
                r_bad_pattern <= 1'b1;
                r_mask        <= 4'h0;
            end else begin
                r_mask <= w_mask_base;
            end
        end
    end

    assign value       = r_value;
    assign valid       = r_valid;
    assign frame_done  = r_frame_done;
    assign bad_pattern = r_bad_pattern;

endmodule
`default_nettype wire

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical-sample cycles required before a digit is accepted; legal range 2..255.
REQ-002 CLK100MHZ  input  1  system clock; all logic on its rising edge.
REQ-003 BTNR  input  1  reset, synchronous, active-high.
REQ-004 seg  input  7  multiplexed segment lines, active-low, seg[0]=a .. seg[6]=g.
REQ-005 an  input  4  digit anodes, active-low; an[0] selects the least significant digit.
REQ-006 value  output  16  last complete decoded frame, digit k in value[4k+3:4k].
REQ-007 valid  output  1  high once at least one complete frame has been published.
REQ-008 frame_done  output  1  one-cycle pulse when value is updated.
REQ-009 bad_pattern  output  1  one-cycle pulse when a settled digit has an undecodable segment pattern.

Function
REQ-010 seg and an SHALL be registered once before use, giving one cycle of input latency.
REQ-011 An anode sample is legal only when exactly one bit of an is 0; all other an values (blank, multi-low) are idle.
REQ-012 The FSM SHALL have states WAIT, SETTLE and HELD.
REQ-013 WAIT: an idle input keeps WAIT; a legal anode moves to SETTLE with the stability counter set to 1.
REQ-014 SETTLE: the counter increments while {an, seg} equals the previous sample.
REQ-015 SETTLE: any change in an or seg restarts the counter at 1 if the new an is legal, else returns to WAIT.
REQ-016 SETTLE: when the counter reaches STABLE_CYCLES, the FSM decodes seg in that same cycle and enters HELD.
REQ-017 HELD: the FSM stays while {an, seg} is unchanged; any change behaves as REQ-015.
REQ-018 Decode table (seg hex -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-019 A valid decode SHALL write the nibble to shadow digit k, where an[k]=0, and set capture-mask bit k.
REQ-020 A recapture of an already-set digit overwrites that shadow digit.
REQ-021 Any pattern not in the REQ-018 table SHALL pulse bad_pattern for one cycle, clear the whole capture mask, and leave shadow and value unchanged.
REQ-022 The cycle after the mask becomes 4'b1111: value <= shadow, frame_done pulses, valid <= 1, mask clears.
REQ-023 A decode in the cycle the frame is published counts toward the next frame.
REQ-024 value SHALL hold between frames; repeated identical frames still pulse frame_done.
REQ-025 Stable time beyond STABLE_CYCLES SHALL NOT produce a second capture of the same digit.

Reset
REQ-026 While BTNR=1 at a clock edge, all of the following clear: state=WAIT, counter=0, shadow=0, mask=0, value=16'h0000, valid=0, frame_done=0, bad_pattern=0, input registers cleared to idle (an=4'hF).
REQ-027 Reset mid-frame discards partial captures; the first frame_done after reset requires four fresh captures.

Verification
REQ-028 Scan an=E,D,B,7 with seg=79,24,30,19, each held 8 cycles -> frame_done once, value=16'h4321, valid=1.
REQ-029 Repeat REQ-028 but hold each digit only 3 cycles (STABLE_CYCLES=4) -> no capture, no frame_done, value remains 16'h0000.
REQ-030 Digit 2 carries seg=7F during a scan -> one bad_pattern pulse, mask cleared, a following clean scan of 0,A,b,F -> value=16'hFBA0.
REQ-031 an=4'hC (two low) or 4'hF between digits -> ignored, no capture; legal scan afterwards publishes normally.
REQ-032 Assert BTNR after three digits captured, then scan a full frame of 8's (seg=00) -> value=16'h0000 and valid=0 until the new frame, then value=16'h8888.
REQ-033 Drive the design's own top-level seg/an outputs through 25 increments and compare value against the expected counter value at each frame_done.
